instr_encoder_loader: RTL and testbench
=======================================

Name: instr_encoder_loader

Overview:
- Encodes field-level RV32I instruction requests into 32-bit machine words and writes them sequentially into instruction memory.
- Covers the same instruction classes the processor's control decoder recognises: R-type, I-type ALU, Load, Store and Branch.
- Sits beside the instruction memory write port and is used for program preload and self-test before the pipeline is released from reset.

Parameters:
- ADDR_WIDTH, 8: word-address width of the instruction memory write port.
- BASE_ADDR, 0: first word address written in each session.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load session; ignored unless in IDLE.
- finish  in  1  end the session after any pending word.
- in_valid  in  1  instruction request valid.
- in_ready  out  1  block can accept a request.
- in_type  in  3  0=R, 1=I-ALU, 2=Load, 3=Store, 4=Branch; 5-7 illegal.
- in_rd  in  5  destination register.
- in_rs1  in  5  source register 1.
- in_rs2  in  5  source register 2.
- in_funct3  in  3  funct3 field.
- in_funct7  in  7  funct7 field; used for R-type only.
- in_imm  in  13  signed immediate.
- mem_we  out  1  instruction memory write strobe.
- mem_addr  out  ADDR_WIDTH  word address.
- mem_wdata  out  32  encoded word.
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at session end.
- count  out  ADDR_WIDTH+1  words written this session.
- err  out  1  sticky error flag; cleared on start.

Behaviour:
- Reset (synchronous, active-high; clk and rst as above):
  - State = IDLE; all outputs 0; write pointer = BASE_ADDR; finish-pending flag cleared.
  - Reset in any state, including mid-WRITE, takes effect at that edge: mem_we is 0 in the following cycle and no partial write occurs.
- FSM states: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - in_ready = 0.
  - start -> ACCEPT; pointer = BASE_ADDR, count = 0, err = 0.
- ACCEPT:
  - in_ready = 1, except when finish-pending is set.
  - Handshake is in_valid & in_ready. A legal request registers mem_wdata and moves to WRITE.
  - An illegal request sets err, is dropped, and the state stays ACCEPT.
  - finish without a handshake -> DONE.
  - finish in the same cycle as a handshake: the word is accepted, finish-pending is set, and the block goes to DONE after WRITE.
- WRITE:
  - mem_we = 1 for exactly one cycle, with mem_addr = pointer; in_ready = 0.
  - At the end of the cycle: pointer += 1, count += 1.
  - Next state is DONE if finish-pending is set, otherwise ACCEPT.
- DONE: done = 1 for one cycle, finish-pending is cleared, then IDLE.
- Timing:
  - A handshake in cycle N gives mem_we in cycle N+1.
  - Peak throughput is one word per 2 cycles.
  - mem_addr and mem_wdata hold their last values outside WRITE.
- Illegal request conditions (any one sets err):
  - in_type >= 5.
  - I, Load or Store with in_imm[12] != in_imm[11], i.e. out of 12-bit signed range.
  - Branch with in_imm[0] = 1.
  - count = 2^ADDR_WIDTH (memory full). The word is dropped; no address wrap.
- Encoding, opcodes:
  - R = 0110011, I = 0010011, Load = 0000011, Store = 0100011, Branch = 1100011.
- Encoding, field layouts:
  - R: {funct7, rs2, rs1, funct3, rd, op}.
  - I / Load: {imm[11:0], rs1, funct3, rd, op}. For I-type shifts the caller supplies the shamt/funct7 bits in imm[11:5].
  - Store: {imm[11:5], rs2, rs1, funct3, imm[4:0], op}.
  - Branch: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], op}.
  - Fields not used by a format are ignored.
- start, in_valid and finish are ignored in IDLE/WRITE/DONE, as applicable to each state above.

Test Plan:
- R-type add: start; R, rd=3, rs1=1, rs2=2, f3=0, f7=0 -> mem_we one cycle after the handshake, addr 0, wdata 0x002081B3, count=1.
- Load and Store: Load rd=5, rs1=2, f3=2, imm=-4, then Store rs1=2, rs2=6, f3=2, imm=8 -> writes 0xFFC12283 @0 and 0x00612423 @1; in_ready=0 during each WRITE.
- Branch: Branch rs1=1, rs2=2, f3=0, imm=-8 -> 0xFE208CE3.
- Errors:
  - in_type=5 -> err=1, no mem_we, count unchanged.
  - Branch with imm=3 -> err=1.
  - Load with imm=2048 -> err=1.
  - A following legal word is still written.
- Finish and full (ADDR_WIDTH=2):
  - Five legal words -> writes at addresses 0-3, 5th dropped with err=1.
  - finish asserted together with a valid word -> that word is written, then done pulses one cycle, busy=0.
- Reset mid-operation: assert rst in the WRITE cycle -> next cycle mem_we=0, state IDLE, count=0, err=0; a new start begins at BASE_ADDR.

Source files
------------

// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader
// Turns field-level RV32I requests (R, I-ALU, Load, Store, Branch) into
// 32-bit machine words and writes them to consecutive instruction memory
// word addresses, starting at BASE_ADDR in every session. It is used for
// program preload and self-test while the pipeline is held in reset.
//
// Ports
//   clk, rst             clock (rising edge), synchronous active-high reset
//   start, finish        open / close a load session
//   in_valid, in_ready   request handshake
//   in_type              0=R 1=I-ALU 2=Load 3=Store 4=Branch (5-7 illegal)
//   in_rd/rs1/rs2        register fields
//   in_funct3/funct7     function fields (funct7 is R-type only)
//   in_imm               13-bit signed immediate
//   mem_we/addr/wdata    instruction memory write port
//   busy, done, count    session status; count = words written
//   err                  sticky error, cleared by start
//
// state  | meaning
// IDLE   | no session; waits for start
// ACCEPT | ready for a request or finish
// WRITE  | one-cycle memory write of the registered word
// DONE   | one-cycle done pulse, then back to IDLE
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  finish,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_type,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [12:0]           in_imm,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  err
);

  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_fin_pend;
  logic                  r_in_ready;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]           r_mem_wdata;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_err;

  logic [31:0] w_enc;
  logic        w_illegal;
  logic        w_full;
  logic        w_hs;

  // count never exceeds 2^ADDR_WIDTH, so its top bit alone flags "full"
  assign w_full = r_count[ADDR_WIDTH];
  assign w_hs   = in_valid & r_in_ready;

  always_comb begin
    w_enc     = '0;
    w_illegal = 1'b0;
    case (in_type)
      3'd0: w_enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, OP_R};
      3'd1: begin
        w_enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_I};
        w_illegal = (in_imm[12] != in_imm[11]);
      end
      3'd2: begin
        w_enc     = {in_imm[11:0], in_rs1, in_funct3, in_rd, OP_LOAD};
        w_illegal = (in_imm[12] != in_imm[11]);
      end
      3'd3: begin
        w_enc     = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OP_STORE};
        w_illegal = (in_imm[12] != in_imm[11]);
      end
      3'd4: begin
        w_enc     = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                     in_imm[4:1], in_imm[11], OP_BRANCH};
        w_illegal = in_imm[0];
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_full) w_illegal = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= BASE;
      r_count     <= '0;
      r_fin_pend  <= 1'b0;
      r_in_ready  <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= 1'b0;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_ACCEPT;
            r_ptr      <= BASE;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
          end
        end
        S_ACCEPT: begin
          if (w_hs && !w_illegal) begin
            r_mem_wdata <= w_enc;
            r_mem_addr  <= r_ptr;
            r_mem_we    <= 1'b1;
            r_in_ready  <= 1'b0;
            r_fin_pend  <= finish;
            r_state     <= S_WRITE;
          end else begin
            // an illegal request is dropped; a concurrent finish still ends
            // the session since no word is left pending
            if (w_hs) r_err <= 1'b1;
            if (finish) begin
              r_in_ready <= 1'b0;
              r_done     <= 1'b1;
              r_state    <= S_DONE;
            end
          end
        end
        S_WRITE: begin
          r_ptr   <= r_ptr + 1'b1;
          r_count <= r_count + 1'b1;
          if (r_fin_pend) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_in_ready <= 1'b1;
            r_state    <= S_ACCEPT;
          end
        end
        S_DONE: begin
          r_fin_pend <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign busy      = r_busy;
  assign done      = r_done;
  assign count     = r_count;
  assign err       = r_err;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench for instr_encoder_loader with a 4-word memory
// (ADDR_WIDTH=2) so the memory-full path is reachable.
module tb_instr_encoder_loader;

  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic          finish;
  logic          in_valid;
  logic          in_ready;
  logic [2:0]    in_type;
  logic [4:0]    in_rd;
  logic [4:0]    in_rs1;
  logic [4:0]    in_rs2;
  logic [2:0]    in_funct3;
  logic [6:0]    in_funct7;
  logic [12:0]   in_imm;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy;
  logic          done;
  logic [AW:0]   count;
  logic          err;

  int checks = 0;
  int errors = 0;

  instr_encoder_loader #(.ADDR_WIDTH(AW), .BASE_ADDR(0)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .finish    (finish),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_type   (in_type),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_funct3 (in_funct3),
    .in_funct7 (in_funct7),
    .in_imm    (in_imm),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .err       (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // waits (bounded) for in_ready, then presents one request for one edge
  task automatic send(input logic [2:0] t, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [12:0] imm, input logic fin);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      step();
      n++;
    end
    chk("ready_wait", 32'(in_ready), 32'h1);
    in_type   = t;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_funct7 = f7;
    in_imm    = imm;
    finish    = fin;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    finish   = 1'b0;
  endtask

  task automatic end_session();
    finish = 1'b1;
    step();
    finish = 1'b0;
    chk("done_pulse", 32'(done), 32'h1);
    step();
    chk("done_clear", 32'(done), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
    in_type = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_funct3 = '0; in_funct7 = '0; in_imm = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_we", 32'(mem_we), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    step();
    chk("idle_ready", 32'(in_ready), 32'h0);

    // session 1: R-type add x3,x1,x2
    do_start();
    chk("start_busy", 32'(busy), 32'h1);
    chk("start_ready", 32'(in_ready), 32'h1);
    send(3'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0, 1'b0);
    chk("add_we", 32'(mem_we), 32'h1);
    chk("add_addr", 32'(mem_addr), 32'h0);
    chk("add_wdata", mem_wdata, 32'h002081B3);
    chk("add_ready", 32'(in_ready), 32'h0);
    step();
    chk("add_we_off", 32'(mem_we), 32'h0);
    chk("add_count", 32'(count), 32'h1);
    chk("add_hold_wdata", mem_wdata, 32'h002081B3);
    chk("add_ready_back", 32'(in_ready), 32'h1);
    end_session();

    // session 2: load, store, branch, then an illegal type and a legal word
    do_start();
    chk("s2_count0", 32'(count), 32'h0);
    send(3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'h1FFC, 1'b0);
    chk("lw_we", 32'(mem_we), 32'h1);
    chk("lw_addr", 32'(mem_addr), 32'h0);
    chk("lw_wdata", mem_wdata, 32'hFFC12283);
    chk("lw_ready", 32'(in_ready), 32'h0);
    step();
    send(3'd3, 5'd0, 5'd2, 5'd6, 3'd2, 7'd0, 13'h0008, 1'b0);
    chk("sw_we", 32'(mem_we), 32'h1);
    chk("sw_addr", 32'(mem_addr), 32'h1);
    chk("sw_wdata", mem_wdata, 32'h00612423);
    chk("sw_ready", 32'(in_ready), 32'h0);
    step();
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h1FF8, 1'b0);
    chk("beq_addr", 32'(mem_addr), 32'h2);
    chk("beq_wdata", mem_wdata, 32'hFE208CE3);
    step();
    chk("s2_count3", 32'(count), 32'h3);
    send(3'd5, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 13'h0, 1'b0);
    chk("t5_we", 32'(mem_we), 32'h0);
    chk("t5_err", 32'(err), 32'h1);
    chk("t5_count", 32'(count), 32'h3);
    chk("t5_ready", 32'(in_ready), 32'h1);
    send(3'd0, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0, 1'b0);
    chk("after_err_we", 32'(mem_we), 32'h1);
    chk("after_err_addr", 32'(mem_addr), 32'h3);
    chk("after_err_wdata", mem_wdata, 32'h00000233);
    step();
    chk("s2_count4", 32'(count), 32'h4);
    end_session();

    // session 3: misaligned branch offset, then addi x1,x0,5
    do_start();
    chk("start_clears_err", 32'(err), 32'h0);
    send(3'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 13'h0003, 1'b0);
    chk("bodd_we", 32'(mem_we), 32'h0);
    chk("bodd_err", 32'(err), 32'h1);
    send(3'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0005, 1'b0);
    chk("addi_we", 32'(mem_we), 32'h1);
    chk("addi_addr", 32'(mem_addr), 32'h0);
    chk("addi_wdata", mem_wdata, 32'h00500093);
    step();
    end_session();

    // session 4: load offset 2048 out of range, then store with finish
    do_start();
    send(3'd2, 5'd5, 5'd2, 5'd0, 3'd2, 7'd0, 13'h0800, 1'b0);
    chk("lrange_we", 32'(mem_we), 32'h0);
    chk("lrange_err", 32'(err), 32'h1);
    send(3'd3, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 13'h1FFF, 1'b1);
    chk("fin_we", 32'(mem_we), 32'h1);
    chk("fin_addr", 32'(mem_addr), 32'h0);
    chk("fin_wdata", mem_wdata, 32'hFE20AFA3);
    chk("fin_no_done_yet", 32'(done), 32'h0);
    step();
    chk("fin_done", 32'(done), 32'h1);
    chk("fin_we_off", 32'(mem_we), 32'h0);
    chk("fin_count", 32'(count), 32'h1);
    step();
    chk("fin_done_off", 32'(done), 32'h0);
    chk("fin_busy", 32'(busy), 32'h0);

    // session 5: fill the 4-word memory, fifth word is dropped
    do_start();
    chk("s5_err_cleared", 32'(err), 32'h0);
    for (int i = 0; i < 4; i++) begin
      send(3'd0, 5'(i + 1), 5'd0, 5'd0, 3'd0, 7'd0, 13'h0, 1'b0);
      chk("fill_addr", 32'(mem_addr), 32'(i));
      chk("fill_wdata", mem_wdata, (32'(i + 1) << 7) | 32'h33);
      step();
    end
    chk("full_count", 32'(count), 32'h4);
    send(3'd0, 5'd9, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0, 1'b0);
    chk("full_we", 32'(mem_we), 32'h0);
    chk("full_err", 32'(err), 32'h1);
    chk("full_count_hold", 32'(count), 32'h4);
    step();
    chk("full_addr_hold", 32'(mem_addr), 32'h3);
    end_session();

    // session 6: reset during a WRITE cycle
    do_start();
    send(3'd6, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0, 1'b0);
    chk("t6_err", 32'(err), 32'h1);
    send(3'd0, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0, 1'b0);
    step();
    send(3'd0, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0, 1'b0);
    chk("midw_we", 32'(mem_we), 32'h1);
    chk("midw_addr", 32'(mem_addr), 32'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_we", 32'(mem_we), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_count", 32'(count), 32'h0);
    chk("midrst_err", 32'(err), 32'h0);
    chk("midrst_ready", 32'(in_ready), 32'h0);
    do_start();
    send(3'd0, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 13'h0, 1'b0);
    chk("restart_addr", 32'(mem_addr), 32'h0);
    chk("restart_wdata", mem_wdata, 32'h000003B3);
    step();
    chk("restart_count", 32'(count), 32'h1);
    end_session();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
